input_port_requester: RTL

- Per-port input side of the router: buffers incoming flits in a circular FIFO.
- On a new packet, raises a routing/arbitration request towards switch control, holds it until granted, then streams the whole packet to the crossbar.
- Acts as the requesting end of the fixed-priority arbitration handshake; one instance per port, up to NPORT instances.

---
 rtl/input_port_requester.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/input_port_requester.sv
`default_nettype none

`ifndef NPORT
`define NPORT 5
`endif

// ============================================================================
//  Module      : input_port_requester
//  Description : Router input port. Buffers upstream flits in a circular
//                FIFO, requests a route for each new packet, waits for the
//                grant and then streams header, size and payload to the
//                crossbar.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_port_requester #(
    parameter int                           FLIT_WIDTH = 16,
    parameter int                           DEPTH      = 16,
    parameter logic [$clog2(`NPORT)-1:0]    PORT_ID    = '0
) (
    input  logic                            clock,
    input  logic                            reset,
    // upstream link
    input  logic                            rx,
    input  logic [FLIT_WIDTH-1:0]           data_in,
    output logic                            credit_o,
    // arbitration handshake
    output logic                            h,
    output logic [$clog2(`NPORT)-1:0]       req_port,
    output logic [FLIT_WIDTH-1:0]           header,
    input  logic                            ack_h,
    // crossbar side
    output logic                            data_av,
    output logic [FLIT_WIDTH-1:0]           data,
    input  logic                            data_ack,
    output logic                            sender
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_SIZE    = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [FLIT_WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q,  count_d;
    logic [2:0]             state_q,  state_d;
    logic [FLIT_WIDTH-1:0]  cnt_q,    cnt_d;

    logic                   w_empty;
    logic                   w_wr_en;
    logic                   w_rd_en;
    logic [FLIT_WIDTH-1:0]  w_head;

    // FIFO status and handshake qualifiers; everything here comes from
    // registered state so credit_o and data_av have no input-to-output path.
    assign w_empty  = (count_q == '0);
    assign credit_o = (count_q != CNT_W'(DEPTH));
    assign w_wr_en  = rx && credit_o;
    assign w_rd_en  = data_av && data_ack;
    assign w_head   = mem_q[rd_ptr_q];

    assign data     = w_head;
    assign header   = w_head;
    assign req_port = PORT_ID;

    // Flit storage: written only on an accepted flit, no reset needed
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // FIFO pointer and occupancy update; power-of-two depth makes the
    // pointers wrap by natural overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_wr_en, w_rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State register for FIFO, FSM and payload counter
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: request, then header, size and N payload flits
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_h) begin
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                if (w_rd_en) begin
                    state_d = S_SIZE;
                end
            end
            S_SIZE: begin
                if (w_rd_en) begin
                    cnt_d   = w_head;
                    // an empty packet ends on its size flit
                    state_d = (w_head == '0) ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_rd_en) begin
                    cnt_d = cnt_q - FLIT_WIDTH'(1);
                    if (cnt_q == FLIT_WIDTH'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: request while waiting, offer flits only once granted
    always_comb begin
        h       = 1'b0;
        data_av = 1'b0;
        sender  = 1'b0;
        case (state_q)
            S_REQ: begin
                h = 1'b1;
            end
            S_HEADER, S_SIZE, S_PAYLOAD: begin
                sender  = 1'b1;
                data_av = !w_empty;
            end
            default: begin
                h       = 1'b0;
                data_av = 1'b0;
                sender  = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire
